// File: rtl/rvsteel_irq_controller_pkg.sv
// rvsteel_irq_controller_pkg
// Shared definitions for the interrupt controller: register selectors,
// byte offsets, source-count limit, bus FSM states and a byte-mask helper.
package rvsteel_irq_controller_pkg;

  localparam int unsigned MAX_SOURCES = 31;

  localparam logic [3:0] OFFSET_PENDING    = 4'h0;
  localparam logic [3:0] OFFSET_ENABLE     = 4'h4;
  localparam logic [3:0] OFFSET_CLAIM      = 4'h8;
  localparam logic [3:0] OFFSET_IN_SERVICE = 4'hC;

  // Register selector taken from rw_address[3:2]
  typedef enum logic [1:0] {
    REG_PENDING    = OFFSET_PENDING[3:2],
    REG_ENABLE     = OFFSET_ENABLE[3:2],
    REG_CLAIM      = OFFSET_CLAIM[3:2],
    REG_IN_SERVICE = OFFSET_IN_SERVICE[3:2]
  } reg_sel_t;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] strobe);
    return {{8{strobe[3]}}, {8{strobe[2]}}, {8{strobe[1]}}, {8{strobe[0]}}};
  endfunction

endpackage

// File: rtl/rvsteel_irq_gateway.sv
// rvsteel_irq_gateway
// Per-source front end: optional 2-flop synchroniser, rising-edge detector
// with a sticky pending flop (edge mode) or pass-through level (level mode).
// Macro: RVSTEEL_IRQ_CONTROLLER_SYNC_EN adds the synchroniser.
// Ports:
//   clock, reset   system clock, async active-high reset
//   src            raw interrupt line
//   edge_mode      1 = rising-edge triggered, 0 = level triggered
//   clear          write-1-to-clear from the PENDING register (edge only)
//   claim_clear    clear on claim (edge only)
//   pending        pending state seen by the controller
module rvsteel_irq_gateway (
  input  logic clock,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic clear,
  input  logic claim_clear,
  output logic pending
);

  logic src_s;

`ifdef RVSTEEL_IRQ_CONTROLLER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], src};
  end

  assign src_s = sync_q[1];
`else
  assign src_s = src;
`endif

  logic hist_q;
  logic edge_q;

  // A new edge takes priority over a same-cycle clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      hist_q <= src_s;
      if (src_s && !hist_q)          edge_q <= 1'b1;
      else if (clear || claim_clear) edge_q <= 1'b0;
    end
  end

  assign pending = edge_mode ? edge_q : src_s;

endmodule

// File: rtl/rvsteel_irq_controller.sv
// rvsteel_irq_controller
// Bus-attached interrupt controller with per-source enable, pending,
// level/edge mode and claim/complete. Registers (rw_address[3:2]):
//   0x0 PENDING (W1C for edge sources), 0x4 ENABLE, 0x8 CLAIM/COMPLETE,
//   0xC IN_SERVICE (read-only).
// Macro: RVSTEEL_IRQ_CONTROLLER_SYNC_EN enables input synchronisers.
// Ports:
//   clock, reset                    system clock, async active-high reset
//   rw_address, write_data,
//   write_strobe                    bus address / data / byte enables
//   read_request, write_request     bus strobes
//   read_data, read_response,
//   write_response                  bus responses, one cycle after request
//   irq_src                         interrupt lines, bit i = source ID i+1
//   irq                             registered request to core
//   irq_response                    trap-taken pulse (accepted, unused)
module rvsteel_irq_controller
  import rvsteel_irq_controller_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 16,
  parameter logic [31:0] EDGE_MASK   = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            rw_address,
  output logic [31:0]            read_data,
  input  logic                   read_request,
  output logic                   read_response,
  input  logic [31:0]            write_data,
  input  logic [3:0]             write_strobe,
  input  logic                   write_request,
  output logic                   write_response,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic                   irq,
  input  logic                   irq_response
);

  localparam int unsigned N = NUM_SOURCES;

  bus_state_t     state_q, state_d;
  logic           rd_q, wr_q;
  reg_sel_t       sel_q;
  logic [31:0]    wdata_q, wmask_q;

  logic [N-1:0]   pending, enable_q, in_service_q;
  logic [N-1:0]   active, claim_vec, clear_vec, complete_vec;
  logic [5:0]     claim_id;
  logic [31:0]    reg_value, complete_val;
  logic           resp, do_read, do_write;

  logic unused;
  assign unused = ^{rw_address[31:4], rw_address[1:0], irq_response};

  // Bus FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= BUS_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = BUS_IDLE;
    if (read_request || write_request) state_d = BUS_RESP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sel_q   <= REG_PENDING;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (read_request || write_request) begin
      rd_q    <= read_request;
      wr_q    <= write_request;
      sel_q   <= reg_sel_t'(rw_address[3:2]);
      wdata_q <= write_data;
      wmask_q <= byte_mask(write_strobe);
    end
  end

  assign resp           = (state_q == BUS_RESP);
  assign read_response  = resp && rd_q;
  assign write_response = resp && wr_q;
  // A read that coincides with a write returns 0 and has no claim effect
  assign do_read        = read_response && !wr_q;
  assign do_write       = write_response;

  // Gateways
  for (genvar g = 0; g < N; g++) begin : g_src
    rvsteel_irq_gateway u_gateway (
      .clock       (clock),
      .reset       (reset),
      .src         (irq_src[g]),
      .edge_mode   (EDGE_MASK[g]),
      .clear       (clear_vec[g]),
      .claim_clear (claim_vec[g]),
      .pending     (pending[g])
    );
  end

  assign active = pending & enable_q & ~in_service_q;

  // Lowest index wins: scan from the top so lower indices overwrite
  always_comb begin
    claim_id = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (active[i-1]) claim_id = 6'(i);
    end
  end

  always_comb begin
    reg_value = '0;
    case (sel_q)
      REG_PENDING:    reg_value[N-1:0] = pending;
      REG_ENABLE:     reg_value[N-1:0] = enable_q;
      REG_CLAIM:      reg_value[5:0]   = claim_id;
      REG_IN_SERVICE: reg_value[N-1:0] = in_service_q;
      default:        reg_value        = '0;
    endcase
  end

  assign read_data    = do_read ? reg_value : '0;
  assign complete_val = wdata_q & wmask_q;

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    clear_vec    = '0;
    if (do_write && sel_q == REG_PENDING) clear_vec = complete_val[N-1:0];
    for (int unsigned i = 0; i < N; i++) begin
      if (do_read && sel_q == REG_CLAIM && claim_id == 6'(i + 1))
        claim_vec[i] = 1'b1;
      if (do_write && sel_q == REG_CLAIM && complete_val == 32'(i + 1))
        complete_vec[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q     <= '0;
      in_service_q <= '0;
      irq          <= 1'b0;
    end else begin
      if (do_write && sel_q == REG_ENABLE)
        enable_q <= (enable_q & ~wmask_q[N-1:0]) | (wdata_q[N-1:0] & wmask_q[N-1:0]);
      in_service_q <= (in_service_q & ~complete_vec) | claim_vec;
      irq          <= |active;
    end
  end

endmodule
